// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter: round-robin byte arbiter with message lock feeding an 8N1 TX
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       cfg_div,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              ser_tx,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          lock_q, lock_d;
  logic [7:0]    data_q, data_d;
  logic [31:0]   div_q, div_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [GW-1:0] cand;
  logic [GW-1:0] idx;
  logic          found;
  logic          accept;
  logic [7:0]    cand_data;
  logic [31:0]   div_eff;
  logic          bit_end;

  // Round-robin search starting just after the last grant; a held lock pins the owner.
  always_comb begin
    cand  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    if (lock_q) begin
      found = req_valid[ptr_q];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (idx == GW'(NREQ - 1)) ? '0 : idx + 1'b1;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          cand  = idx;
        end
      end
    end
  end

  always_comb begin
    cand_data = 8'h00;
    for (int r = 0; r < NREQ; r++) begin
      if (GW'(r) == cand) begin
        cand_data = req_data[r*8 +: 8];
      end
    end
  end

  // Ready is gated by resetn so no strobe is seen while reset is asserted.
  assign accept  = (state_q == S_IDLE) && found && resetn;
  assign div_eff = (cfg_div < 32'd2) ? 32'd2 : cfg_div;
  assign bit_end = (cnt_q == div_q - 32'd1);

  always_comb begin
    req_ready       = '0;
    req_ready[cand] = accept;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    data_d  = data_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = cand_data;
          div_d   = div_eff;
          grant_d = cand;
          ptr_d   = cand;
          lock_d  = ~req_last[cand];
          cnt_d   = 32'd0;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = 32'd0;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = 32'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = 32'd0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pointer resets to the last requester so requester 0 wins the first grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(NREQ - 1);
      grant_q <= '0;
      lock_q  <= 1'b0;
      data_q  <= 8'h00;
      div_q   <= 32'd2;
      cnt_q   <= 32'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign ser_tx   = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

`default_nettype wire
